vga_timing_monitor: RTL and testbench
=====================================

# vga_timing_monitor

Synthesizable checker that sits directly downstream of `wrapper_digit10`. It consumes the wrapper's `hsync`/`vsync`/`rgb` outputs on the same clock and measures line and frame timing against parameters. It reports sticky timing errors, a lock indication and a frame counter, and optionally a per-frame count of lit pixels. It replaces file-based inspection of the video stream with hardware-checkable status.

## Interface

**Parameters**

- `H_TOTAL`, 309: pixels per line
- `H_SYNC`, 23: hsync low width, in pixels
- `V_TOTAL`, 262: lines per frame
- `V_SYNC`, 3: vsync low width, in lines
- `CLK_PER_PIX`, 2: clocks per pixel

**Ports**

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-low reset
- `hsync` in 1: horizontal sync from wrapper, active-low pulse
- `vsync` in 1: vertical sync from wrapper, active-low pulse
- `rgb` in 3: pixel colour from wrapper
- `clr_err` in 1: synchronous clear of sticky error flags
- `locked` out 1: timing stable
- `frame_cnt` out 16: frames seen while locked
- `line_len` out 12: last measured hsync period, in clocks
- `frame_lines` out 10: last measured vsync period, in lines
- `err_hperiod`, `err_hwidth`, `err_vperiod`, `err_vwidth` out 1 each: sticky error flags
- `px_count` out 20: lit pixels in the last frame (only with `VGA_MON_PX_STATS_EN`)

## Operation

- **Input registers.** `hsync`, `vsync` and `rgb` are registered twice (`s1`, `s2`).
  - Fall is `s2 & ~s1`; rise is `~s2 & s1`.
  - All logic below runs on the `s1`/`s2` stage.
- **Horizontal counting.**
  - `hcnt` is loaded with 1 on an hsync fall and otherwise increments, saturating at 4095.
  - On each hsync fall, `line_len <= hcnt` and the period is compared with `H_TOTAL*CLK_PER_PIX`.
  - `hlow` counts clocks with hsync low. On an hsync rise it is compared with `H_SYNC*CLK_PER_PIX`.
- **Vertical counting.**
  - `lcnt` increments on each hsync fall and saturates at 1023.
  - On a vsync fall, `frame_lines <= lcnt`, the value is compared with `V_TOTAL`, then `lcnt` is loaded with 0.
  - `vlow` counts hsync falls while vsync is low. On a vsync rise it is compared with `V_SYNC`.
- **Comparisons.**
  - Comparisons are evaluated only in MEASURE and LOCKED. The first edge after SEARCH is never checked.
  - A mismatch sets the matching `err_*` flag, which stays set until `clr_err`.
  - If `clr_err` and a new error occur in the same cycle, the error wins and the flag reads 1.
- **State machine** (states SEARCH, MEASURE, LOCKED):
  - SEARCH: wait for a vsync fall, then go to MEASURE with `good` = 0.
  - MEASURE, on a vsync fall:
    - If the frame just ended had no mismatch, `good++`.
    - Otherwise `good` = 0.
    - When `good` reaches 2, go to LOCKED.
  - Any mismatch in MEASURE clears `good` immediately.
  - LOCKED: any mismatch returns to MEASURE with `good` = 0.
  - `locked` = 1 only in LOCKED.
- **Frame counter.** `frame_cnt` increments on each vsync fall while in LOCKED, including the fall that enters LOCKED. It wraps from 0xFFFF to 0.
- **Reset** (asynchronous, any time including mid-frame):
  - All outputs, counters and flags go to 0 and the state goes to SEARCH.
  - `hcnt`, `hlow`, `lcnt` and `vlow` clear to 0.
  - Input registers reset to 1 (sync idle), so release does not create a false fall.

## Timing

- An input edge sampled at clock edge N is detected at edge N+1.
  - `line_len`, `frame_lines`, `err_*`, the state, `locked` and `frame_cnt` are updated at edge N+2 and visible after it.
- `clr_err` is registered: flags clear at the edge after `clr_err` is sampled high.
- Lock latency from a clean start: asserted 2 clocks after the 3rd input vsync fall.
  - 1st fall enters MEASURE.
  - 2nd fall sets `good` = 1.
  - 3rd fall sets `good` = 2 and enters LOCKED.
- Nominal frame is 618 × 262 = 161,916 clocks.

## Configuration

Macro `VGA_MON_PX_STATS_EN` controls per-frame pixel statistics.

- **Defined:**
  - A pixel phase counter is cleared on each hsync fall and wraps at `CLK_PER_PIX-1`.
  - At phase `CLK_PER_PIX-1`, if `s2` hsync, `s2` vsync are both 1 and `s2` rgb ≠ 0, `pcnt++` (saturating at 2^20-1).
  - On a vsync fall, `px_count <= pcnt` and `pcnt` clears.
  - This runs in every state.
- **Not defined:** the `px_count` port is absent and no statistics logic is built.

## Test plan

- Reset low for 7 clocks, then nominal wrapper-style timing (618-clock lines, 46-clock hsync low, 262 lines, 3-line vsync low):
  - `locked` = 1 two clocks after the 3rd vsync fall, and `frame_cnt` = 1 then.
  - `line_len` = 618, `frame_lines` = 262, all `err_*` = 0.
- While locked, make one line 616 clocks:
  - `err_hperiod` = 1 and `locked` = 0 two clocks after the short line's closing hsync fall.
  - Relock at the 2nd vsync fall after the next vsync fall, i.e. after 2 clean frames.
- vsync low for 4 lines while locked: `err_vwidth` = 1 two clocks after the vsync rise, and `locked` = 0.
- Pulse `clr_err` in the same cycle that a 40-clock hsync low ends: `err_hwidth` reads 1 afterwards. A later isolated `clr_err` pulse clears it to 0.
- Assert reset mid-frame while locked with `frame_cnt` = 5:
  - All outputs are 0 immediately, without waiting for a clock.
  - After release with nominal stimulus, relock takes 3 vsync falls.
- `VGA_MON_PX_STATS_EN` defined with constant `rgb` = 7 and nominal timing: after any complete frame `px_count` = 286 × 259 = 74,074. With `rgb` = 0 it is 0.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Line/frame timing checker for the wrapper_digit10 video stream: sticky errors, lock, frame count.
// Optional per-frame lit-pixel statistics when VGA_MON_PX_STATS_EN is defined.
module vga_timing_monitor #(
    parameter int H_TOTAL     = 309,
    parameter int H_SYNC      = 23,
    parameter int V_TOTAL     = 262,
    parameter int V_SYNC      = 3,
    parameter int CLK_PER_PIX = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    input  logic        clr_err,
    output logic        locked,
    output logic [15:0] frame_cnt,
    output logic [11:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        err_hperiod,
    output logic        err_hwidth,
    output logic        err_vperiod,
    output logic        err_vwidth
`ifdef VGA_MON_PX_STATS_EN
    ,
    output logic [19:0] px_count
`endif
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam logic [11:0] H_PER = 12'(H_TOTAL * CLK_PER_PIX);
    localparam logic [11:0] H_SW  = 12'(H_SYNC * CLK_PER_PIX);
    localparam logic [9:0]  V_TOT = 10'(V_TOTAL);
    localparam logic [9:0]  V_SW  = 10'(V_SYNC);

    logic        hs_s1, hs_s2, vs_s1, vs_s2;
    logic        hfall, hrise, vfall, vrise;
    logic [11:0] hcnt, hlow, hcnt_snap;
    logic [9:0]  lcnt, vlow, lcnt_snap;
    logic        hf_q, hr_q, vf_q, vr_q;
    logic        hper_bad, hw_bad, vper_bad, vw_bad;
    logic        clr_q;

    logic [1:0]  state, good;
    logic        frame_bad;
    logic        checking, mis_hp, mis_hw, mis_vp, mis_vw, mis_any;

    assign hfall = hs_s2 & ~hs_s1;
    assign hrise = ~hs_s2 & hs_s1;
    assign vfall = vs_s2 & ~vs_s1;
    assign vrise = ~vs_s2 & vs_s1;

    // Detection stage: counters act on the raw edges, results are snapshotted for the next stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_s1     <= 1'b1;
            hs_s2     <= 1'b1;
            vs_s1     <= 1'b1;
            vs_s2     <= 1'b1;
            hcnt      <= '0;
            hlow      <= '0;
            lcnt      <= '0;
            vlow      <= '0;
            hcnt_snap <= '0;
            lcnt_snap <= '0;
            hf_q      <= 1'b0;
            hr_q      <= 1'b0;
            vf_q      <= 1'b0;
            vr_q      <= 1'b0;
            hper_bad  <= 1'b0;
            hw_bad    <= 1'b0;
            vper_bad  <= 1'b0;
            vw_bad    <= 1'b0;
            clr_q     <= 1'b0;
        end else begin
            hs_s1 <= hsync;
            hs_s2 <= hs_s1;
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            clr_q <= clr_err;

            if (hfall)
                hcnt <= 12'd1;
            else if (hcnt != 12'hFFF)
                hcnt <= hcnt + 12'd1;

            if (hfall)
                hlow <= 12'd1;
            else if (!hs_s1 && hlow != 12'hFFF)
                hlow <= hlow + 12'd1;

            // A line start coinciding with the frame start belongs to the new frame.
            if (vfall)
                lcnt <= {9'd0, hfall};
            else if (hfall && lcnt != 10'h3FF)
                lcnt <= lcnt + 10'd1;

            if (vfall)
                vlow <= {9'd0, hfall};
            else if (hfall && !vs_s1 && vlow != 10'h3FF)
                vlow <= vlow + 10'd1;

            hf_q <= hfall;
            hr_q <= hrise;
            vf_q <= vfall;
            vr_q <= vrise;

            if (hfall) begin
                hcnt_snap <= hcnt;
                hper_bad  <= (hcnt != H_PER);
            end
            if (vfall) begin
                lcnt_snap <= lcnt;
                vper_bad  <= (lcnt != V_TOT);
            end
            hw_bad <= (hlow != H_SW);
            vw_bad <= (vlow != V_SW);
        end
    end

    always_comb begin
        checking = (state == MEASURE) || (state == LOCKED);
        mis_hp   = hf_q & hper_bad;
        mis_hw   = hr_q & hw_bad;
        mis_vp   = vf_q & vper_bad;
        mis_vw   = vr_q & vw_bad;
        mis_any  = checking & (mis_hp | mis_hw | mis_vp | mis_vw);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= SEARCH;
            good        <= '0;
            frame_bad   <= 1'b0;
            frame_cnt   <= '0;
            line_len    <= '0;
            frame_lines <= '0;
            err_hperiod <= 1'b0;
            err_hwidth  <= 1'b0;
            err_vperiod <= 1'b0;
            err_vwidth  <= 1'b0;
        end else begin
            if (hf_q)
                line_len <= hcnt_snap;
            if (vf_q)
                frame_lines <= lcnt_snap;

            // A new error outranks a simultaneous clear.
            err_hperiod <= (checking & mis_hp) | (err_hperiod & ~clr_q);
            err_hwidth  <= (checking & mis_hw) | (err_hwidth & ~clr_q);
            err_vperiod <= (checking & mis_vp) | (err_vperiod & ~clr_q);
            err_vwidth  <= (checking & mis_vw) | (err_vwidth & ~clr_q);

            case (state)
                SEARCH: begin
                    if (vf_q) begin
                        state     <= MEASURE;
                        good      <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (vf_q) begin
                        frame_bad <= 1'b0;
                        if (mis_any || frame_bad) begin
                            good <= '0;
                        end else if (good == 2'd1) begin
                            good      <= 2'd2;
                            state     <= LOCKED;
                            frame_cnt <= frame_cnt + 16'd1;
                        end else begin
                            good <= good + 2'd1;
                        end
                    end else if (mis_any) begin
                        good      <= '0;
                        frame_bad <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (vf_q)
                        frame_cnt <= frame_cnt + 16'd1;
                    if (mis_any) begin
                        state     <= MEASURE;
                        good      <= '0;
                        frame_bad <= ~vf_q;
                    end
                end
                default: begin
                    state <= SEARCH;
                    good  <= '0;
                end
            endcase
        end
    end

    assign locked = (state == LOCKED);

`ifdef VGA_MON_PX_STATS_EN
    localparam logic [7:0] PH_LAST = 8'(CLK_PER_PIX - 1);

    logic [2:0]  rgb_s1, rgb_s2;
    logic [7:0]  phase;
    logic [19:0] pcnt;
    logic        px_hit;

    assign px_hit = (phase == PH_LAST) && hs_s2 && vs_s2 && (rgb_s2 != 3'd0);

    // The pixel sampled on the frame-start cycle still belongs to the closing frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rgb_s1   <= '0;
            rgb_s2   <= '0;
            phase    <= '0;
            pcnt     <= '0;
            px_count <= '0;
        end else begin
            rgb_s1 <= rgb;
            rgb_s2 <= rgb_s1;

            if (hfall || phase == PH_LAST)
                phase <= '0;
            else
                phase <= phase + 8'd1;

            if (vfall) begin
                px_count <= (px_hit && pcnt != 20'hFFFFF) ? pcnt + 20'd1 : pcnt;
                pcnt     <= '0;
            end else if (px_hit && pcnt != 20'hFFFFF) begin
                pcnt <= pcnt + 20'd1;
            end
        end
    end
`else
    logic rgb_unused;
    assign rgb_unused = ^rgb;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced raster (40-clock lines, 12-line frames).
// Expected values are queued with a due cycle when stimulus is driven and checked when that cycle arrives.
module tb_vga_timing_monitor;

    localparam int HT  = 20;
    localparam int HS  = 3;
    localparam int VT  = 12;
    localparam int VS  = 3;
    localparam int CPP = 2;
    localparam int LL  = HT * CPP;
    localparam int HLW = HS * CPP;

    localparam int C_LCK   = 0;
    localparam int C_FCNT  = 1;
    localparam int C_LLEN  = 2;
    localparam int C_FLIN  = 3;
    localparam int C_EHP   = 4;
    localparam int C_EHW   = 5;
    localparam int C_EVP   = 6;
    localparam int C_EVW   = 7;
    localparam int C_PX    = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsync, vsync, clr_err;
    logic [2:0]  rgb;
    logic        locked;
    logic [15:0] frame_cnt;
    logic [11:0] line_len;
    logic [9:0]  frame_lines;
    logic        err_hperiod, err_hwidth, err_vperiod, err_vwidth;
`ifdef VGA_MON_PX_STATS_EN
    logic [19:0] px_count;
`endif

    always #5 clk = ~clk;

    vga_timing_monitor #(
        .H_TOTAL     (HT),
        .H_SYNC      (HS),
        .V_TOTAL     (VT),
        .V_SYNC      (VS),
        .CLK_PER_PIX (CPP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb),
        .clr_err     (clr_err),
        .locked      (locked),
        .frame_cnt   (frame_cnt),
        .line_len    (line_len),
        .frame_lines (frame_lines),
        .err_hperiod (err_hperiod),
        .err_hwidth  (err_hwidth),
        .err_vperiod (err_vperiod),
        .err_vwidth  (err_vwidth)
`ifdef VGA_MON_PX_STATS_EN
        ,
        .px_count    (px_count)
`endif
    );

    typedef struct {
        int          due;
        int          code;
        logic [19:0] val;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [19:0] observe(input int code);
        case (code)
            C_LCK:   observe = 20'(locked);
            C_FCNT:  observe = 20'(frame_cnt);
            C_LLEN:  observe = 20'(line_len);
            C_FLIN:  observe = 20'(frame_lines);
            C_EHP:   observe = 20'(err_hperiod);
            C_EHW:   observe = 20'(err_hwidth);
            C_EVP:   observe = 20'(err_vperiod);
            C_EVW:   observe = 20'(err_vwidth);
`ifdef VGA_MON_PX_STATS_EN
            C_PX:    observe = px_count;
`endif
            default: observe = 20'hFFFFF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // off = position of the relevant sample in the upcoming stimulus + 3 (sample edge, detect, update).
    task automatic expect_at(input int off, input int code, input logic [19:0] val, input string tag);
        exp_t e;
        e.due  = cyc + off;
        e.code = code;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic step(input logic hs, input logic vs, input logic clr);
        hsync   = hs;
        vsync   = vs;
        clr_err = clr;
        @(posedge clk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check(sb[i].tag, observe(sb[i].code), sb[i].val);
                sb.delete(i);
            end
        end
    endtask

    task automatic drive_line(input int len, input int hl, input logic vs, input int clr_at);
        for (int i = 0; i < len; i++)
            step(logic'(i >= hl), vs, logic'(i == clr_at));
    endtask

    task automatic drive_frame(input int vs_lines, input int sp_line, input int sp_len,
                               input int sp_hl, input int sp_clr);
        for (int l = 0; l < VT; l++) begin
            if (l == sp_line)
                drive_line(sp_len, sp_hl, logic'(l >= vs_lines), sp_clr);
            else
                drive_line(LL, HLW, logic'(l >= vs_lines), -1);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_locked"},      20'(locked),      20'd0);
        check({pfx, "_frame_cnt"},   20'(frame_cnt),   20'd0);
        check({pfx, "_line_len"},    20'(line_len),    20'd0);
        check({pfx, "_frame_lines"}, 20'(frame_lines), 20'd0);
        check({pfx, "_errs"}, 20'({err_hperiod, err_hwidth, err_vperiod, err_vwidth}), 20'd0);
`ifdef VGA_MON_PX_STATS_EN
        check({pfx, "_px_count"},    px_count,         20'd0);
`endif
    endtask

    initial begin
        reset   = 1'b1;
        hsync   = 1'b1;
        vsync   = 1'b1;
        clr_err = 1'b0;
        rgb     = 3'd7;
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (7) step(1'b1, 1'b1, 1'b0);
        check_all_zero("reset_held");
        reset = 1'b1;
        repeat (4) step(1'b1, 1'b1, 1'b0);

        // Clean start: lock two clocks after the third vsync fall.
        drive_frame(VS, -1, 0, 0, -1);
        expect_at(3, C_LCK, 0, "no_lock_2nd_vfall");
        drive_frame(VS, -1, 0, 0, -1);
        expect_at(2, C_LCK,  0,  "lock_not_early");
        expect_at(3, C_LCK,  1,  "lock_3rd_vfall");
        expect_at(3, C_FCNT, 1,  "fcnt_at_lock");
        expect_at(3, C_LLEN, LL, "line_len_nominal");
        expect_at(3, C_FLIN, VT, "frame_lines_nominal");
        expect_at(3, C_EHP,  0,  "ehp_clean");
        expect_at(3, C_EHW,  0,  "ehw_clean");
        expect_at(3, C_EVP,  0,  "evp_clean");
        expect_at(3, C_EVW,  0,  "evw_clean");
`ifdef VGA_MON_PX_STATS_EN
        expect_at(3, C_PX, (HT - HS) * (VT - VS), "px_count_frame");
`endif
        drive_frame(VS, -1, 0, 0, -1);

        // Short line 5 (38 clocks); its closing hsync fall is line 6 start at position 238.
        expect_at(3,   C_FCNT, 2,  "fcnt_locked_frame");
        expect_at(240, C_EHP,  0,  "ehp_before_short");
        expect_at(240, C_LCK,  1,  "locked_before_short");
        expect_at(241, C_EHP,  1,  "ehp_short_line");
        expect_at(241, C_LCK,  0,  "unlock_short_line");
        expect_at(241, C_LLEN, LL - 2, "line_len_short");
        drive_frame(VS, 5, LL - 2, HLW, -1);

        expect_at(3, C_LCK,  0,  "no_relock_bad_frame");
        expect_at(3, C_FCNT, 2,  "fcnt_frozen");
        expect_at(3, C_FLIN, VT, "frame_lines_after_short");
        drive_frame(VS, -1, 0, 0, -1);
        expect_at(3, C_LCK, 0, "no_relock_one_clean");
        drive_frame(VS, -1, 0, 0, -1);

        // Relock; isolated clr_err at line 4 index 20 (position 180).
        expect_at(2,   C_LCK,  0, "relock_not_early");
        expect_at(3,   C_LCK,  1, "relock_two_clean");
        expect_at(3,   C_FCNT, 3, "fcnt_relock");
        expect_at(3,   C_EHP,  1, "ehp_sticky");
        expect_at(181, C_EHP,  1, "ehp_before_clr");
        expect_at(182, C_EHP,  0, "ehp_cleared");
        drive_frame(VS, 4, LL, HLW, 20);

        // vsync low for 4 lines: vsync rise at line 4 start (position 160).
        expect_at(3,   C_FCNT, 4, "fcnt_before_vw");
        expect_at(162, C_EVW,  0, "evw_before_rise");
        expect_at(162, C_LCK,  1, "locked_before_vw");
        expect_at(163, C_EVW,  1, "evw_long_vsync");
        expect_at(163, C_LCK,  0, "unlock_long_vsync");
        drive_frame(4, -1, 0, 0, -1);

        // 4-clock hsync low on line 2 ends at position 84; clr_err lands on the same update edge.
        expect_at(3,  C_LCK, 0, "measure_after_vw");
        expect_at(86, C_EHW, 0, "ehw_before_rise");
        expect_at(86, C_EVW, 1, "evw_before_clr");
        expect_at(87, C_EHW, 1, "ehw_wins_over_clr");
        expect_at(87, C_EVW, 0, "evw_cleared");
        expect_at(90, C_EHW, 1, "ehw_holds");
        drive_frame(VS, 2, LL, HLW - 2, HLW - 1);

        expect_at(3,  C_LCK, 0, "no_relock_hw_frame");
        expect_at(51, C_EHW, 1, "ehw_before_clr");
        expect_at(52, C_EHW, 0, "ehw_isolated_clr");
        drive_frame(VS, 1, LL, HLW, 10);
        expect_at(3, C_LCK, 0, "no_relock_one_clean_b");
        drive_frame(VS, -1, 0, 0, -1);

        // Relock to frame_cnt 5, then reset in the middle of the frame.
        expect_at(2, C_LCK,  0, "relock_b_not_early");
        expect_at(3, C_LCK,  1, "relock_b");
        expect_at(3, C_FCNT, 5, "fcnt_five");
        expect_at(3, C_EVP,  0, "evp_never_set");
        for (int l = 0; l < 5; l++)
            drive_line(LL, HLW, logic'(l >= VS), -1);
        drive_line(LL / 2, HLW, 1'b1, -1);
        check("locked_before_reset", 20'(locked), 20'd1);
        reset = 1'b0;
        #1 check_all_zero("reset_mid_frame");
        repeat (3) step(1'b1, 1'b1, 1'b0);
        reset = 1'b1;
        for (int l = 6; l < VT; l++)
            drive_line(LL, HLW, 1'b1, -1);

        drive_frame(VS, -1, 0, 0, -1);
        expect_at(3, C_LCK, 0, "post_reset_2nd_vfall");
        drive_frame(VS, -1, 0, 0, -1);
        expect_at(2, C_LCK,  0, "post_reset_not_early");
        expect_at(3, C_LCK,  1, "post_reset_relock");
        expect_at(3, C_FCNT, 1, "post_reset_fcnt");
        drive_frame(VS, -1, 0, 0, -1);

        repeat (4) step(1'b1, 1'b1, 1'b0);
        check("scoreboard_drained", 20'(sb.size()), 20'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
